// File: rtl/multi_timer.sv
// ---------------------------------------------------------------------------
// multi_timer: N_CH-channel programmable timer with a shared prescaler.
//
// Each channel counts prescaler ticks up to its compare value. It then sets
// a sticky pending bit and either restarts (periodic) or parks in DONE
// (one-shot). Pending bits are masked and OR-ed onto a single interrupt line.
//
// Optional feature macro: MULTI_TIMER_PWM_EN adds i_duty / o_pwm, a per-channel
// PWM output derived from the channel counter.
//
// Interface semantics: there is no valid/ready handshake in this block.
// Level inputs (i_global_en, i_prescale, i_value, i_mode, i_enable,
// i_irq_mask, i_duty) are sampled on every rising clock edge. i_clear and
// i_irq_ack are single-cycle pulses that act on the edge where they are high.
//
// Channel state is held in r_state[] (IDLE / RUN / DONE) so that checkers can
// bind to it directly.
// ---------------------------------------------------------------------------
module multi_timer #(
    parameter int N_REG = 32,
    parameter int N_CH  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_global_en,
    input  logic [N_REG-1:0]       i_prescale,
    input  logic [N_CH*N_REG-1:0]  i_value,
    input  logic [N_CH-1:0]        i_mode,
    input  logic [N_CH-1:0]        i_enable,
    input  logic [N_CH-1:0]        i_clear,
    input  logic [N_CH-1:0]        i_irq_ack,
    input  logic [N_CH-1:0]        i_irq_mask,
`ifdef MULTI_TIMER_PWM_EN
    input  logic [N_CH*N_REG-1:0]  i_duty,
    output logic [N_CH-1:0]        o_pwm,
`endif
    output logic [N_CH-1:0]        o_pending,
    output logic [N_CH-1:0]        o_running,
    output logic                   o_irq
);

    localparam logic [N_REG-1:0] L_ONE = {{(N_REG-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Prescaler
    logic [N_REG-1:0] r_pre_cnt;
    logic [N_REG-1:0] w_pre_nxt;
    logic             w_tick;

    // Per-channel state
    state_t           r_state     [N_CH];
    state_t           w_state_nxt [N_CH];
    logic [N_REG-1:0] r_cnt       [N_CH];
    logic [N_REG-1:0] w_cnt_nxt   [N_CH];
    logic [N_CH-1:0]  r_pending;
    logic [N_CH-1:0]  w_pending_nxt;
    logic [N_CH-1:0]  w_expire;

    // Prescaler next value and tick. The tick fires only on exact equality, so
    // lowering i_prescale below the current count lets the counter wrap first.
    always_comb begin
        w_tick    = 1'b0;
        w_pre_nxt = '0;
        if (i_global_en) begin
            w_tick    = (r_pre_cnt == i_prescale);
            w_pre_nxt = w_tick ? '0 : (r_pre_cnt + L_ONE);
        end
    end

    // Prescaler register; disabling the global enable restarts it from zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= w_pre_nxt;
        end
    end

    // Channel next-state, counter and pending logic.
    // Priority: clear > expiry > ack. Pause (enable low in RUN) takes
    // precedence over a tick in the same cycle, and the counter holds.
    always_comb begin
        w_expire      = '0;
        w_pending_nxt = r_pending;
        for (int c = 0; c < N_CH; c++) begin
            w_state_nxt[c] = r_state[c];
            w_cnt_nxt[c]   = r_cnt[c];
            if (i_clear[c]) begin
                w_state_nxt[c] = ST_IDLE;
                w_cnt_nxt[c]   = '0;
            end else begin
                case (r_state[c])
                    ST_IDLE: begin
                        if (i_enable[c]) begin
                            w_state_nxt[c] = ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (!i_enable[c]) begin
                            w_state_nxt[c] = ST_IDLE;
                        end else if (w_tick) begin
                            if (r_cnt[c] == i_value[c*N_REG +: N_REG]) begin
                                w_expire[c]  = 1'b1;
                                w_cnt_nxt[c] = '0;
                                if (i_mode[c]) begin
                                    w_state_nxt[c] = ST_DONE;
                                end
                            end else begin
                                w_cnt_nxt[c] = r_cnt[c] + L_ONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        w_cnt_nxt[c] = '0;
                    end
                    default: begin
                        w_state_nxt[c] = ST_IDLE;
                        w_cnt_nxt[c]   = '0;
                    end
                endcase
            end

            if (i_clear[c]) begin
                w_pending_nxt[c] = 1'b0;
            end else if (w_expire[c]) begin
                w_pending_nxt[c] = 1'b1;
            end else if (i_irq_ack[c]) begin
                w_pending_nxt[c] = 1'b0;
            end
        end
    end

    // Channel state, counter and sticky pending registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                r_state[c] <= ST_IDLE;
                r_cnt[c]   <= '0;
            end
            r_pending <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                r_state[c] <= w_state_nxt[c];
                r_cnt[c]   <= w_cnt_nxt[c];
            end
            r_pending <= w_pending_nxt;
        end
    end

`ifdef MULTI_TIMER_PWM_EN
    logic [N_CH-1:0] r_pwm;

    // PWM register, aligned with the channel registers: high while the
    // channel is running and its counter is below the duty value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pwm <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                r_pwm[c] <= (w_state_nxt[c] == ST_RUN) &&
                            (w_cnt_nxt[c] < i_duty[c*N_REG +: N_REG]);
            end
        end
    end

    assign o_pwm = r_pwm;
`endif

    // Running flags decode the registered channel state.
    always_comb begin
        o_running = '0;
        for (int c = 0; c < N_CH; c++) begin
            o_running[c] = (r_state[c] == ST_RUN);
        end
    end

    assign o_pending = r_pending;
    assign o_irq     = |(r_pending & i_irq_mask);

endmodule

// File: tb/tb_multi_timer.sv
// ---------------------------------------------------------------------------
// tb_multi_timer: directed bench for multi_timer (N_REG=32, N_CH=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_multi_timer;

  localparam int N_REG = 32;
  localparam int N_CH  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                  global_en;
  logic [N_REG-1:0]      prescale;
  logic [N_CH*N_REG-1:0] value;
  logic [N_CH-1:0]       mode;
  logic [N_CH-1:0]       enable;
  logic [N_CH-1:0]       clear;
  logic [N_CH-1:0]       irq_ack;
  logic [N_CH-1:0]       irq_mask;
  logic [N_CH-1:0]       pending;
  logic [N_CH-1:0]       running;
  logic                  irq;
`ifdef MULTI_TIMER_PWM_EN
  logic [N_CH*N_REG-1:0] duty;
  logic [N_CH-1:0]       pwm;
`endif

  multi_timer #(.N_REG(N_REG), .N_CH(N_CH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_global_en (global_en),
    .i_prescale  (prescale),
    .i_value     (value),
    .i_mode      (mode),
    .i_enable    (enable),
    .i_clear     (clear),
    .i_irq_ack   (irq_ack),
    .i_irq_mask  (irq_mask),
`ifdef MULTI_TIMER_PWM_EN
    .i_duty      (duty),
    .o_pwm       (pwm),
`endif
    .o_pending   (pending),
    .o_running   (running),
    .o_irq       (irq)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_value(input int ch, input logic [N_REG-1:0] v);
    value[ch*N_REG +: N_REG] = v;
  endtask

  // Stop every channel, drop all pending bits and restart the prescaler.
  task automatic cleanup();
    enable    = '0;
    global_en = 1'b0;
    irq_ack   = '0;
    clear     = '1;
    tick();
    clear     = '0;
    mode      = '0;
    tick();
  endtask

  // Clocks until o_pending[ch] is seen high, bounded by budget.
  task automatic wait_pend(input int ch, input int budget, output int cycles);
    cycles = 0;
    while (!pending[ch] && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  // comparison point
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    global_en = 1'b0;
    prescale  = '0;
    value     = '0;
    mode      = '0;
    enable    = '0;
    clear     = '0;
    irq_ack   = '0;
    irq_mask  = '0;
`ifdef MULTI_TIMER_PWM_EN
    duty      = '0;
`endif
    run(2);

    // ---- reset held while inputs toggle: outputs stay 0
    for (int i = 0; i < 4; i++) begin
      global_en = 1'($urandom_range(0, 1));
      prescale  = N_REG'($urandom_range(0, 3));
      value     = {$urandom, $urandom, $urandom, $urandom};
      mode      = N_CH'($urandom);
      enable    = '1;
      clear     = N_CH'($urandom);
      irq_ack   = N_CH'($urandom);
      irq_mask  = '1;
      tick();
      chk("rst_hold_pending", pending, 0);
      chk("rst_hold_running", running, 0);
      chk("rst_hold_irq", irq, 0);
    end
    global_en = 1'b0;
    prescale  = '0;
    value     = '0;
    mode      = '0;
    enable    = '0;
    clear     = '0;
    irq_ack   = '0;
    irq_mask  = '0;
    rst_n     = 1'b1;
    run(3);
    chk("rst_rel_pending", pending, 0);
    chk("rst_rel_running", running, 0);
    chk("rst_rel_irq", irq, 0);

    // ---- ch0 periodic, prescale=2, value=100: period 101*3 = 303 clocks.
    // Enable edge puts ch0 in RUN; ticks land every 3rd edge, expiry on the
    // 101st tick = edge 303.
    prescale  = 32'd2;
    set_value(0, 32'd100);
    irq_mask  = '1;
    global_en = 1'b1;
    enable    = 4'b0001;
    wait_pend(0, 400, cyc);
    chk("ch0_first_expiry", cyc, 303);
    chk("ch0_irq_set", irq, 1);
    chk("ch0_running", running, 4'b0001);
    irq_ack[0] = 1'b1;
    tick();
    irq_ack[0] = 1'b0;
    chk("ch0_ack_pending", pending, 0);
    chk("ch0_ack_irq", irq, 0);
    wait_pend(0, 400, cyc);
    // ack edge (1) + wait = distance between expiries
    chk("ch0_period", cyc + 1, 303);
    cleanup();
    chk("cleanup_pending", pending, 0);

    // ---- pause/resume, prescale=0, value=100: unpaused expiry after 102 edges
    prescale  = 32'd0;
    set_value(0, 32'd100);
    global_en = 1'b1;
    enable    = 4'b0001;
    run(41);
    chk("pause_cnt_before", dut.r_cnt[0], 40);
    // Counting stops for 50 clocks: 49 edges with enable low plus the
    // edge that re-enters RUN.
    enable = 4'b0000;
    run(49);
    chk("pause_cnt_hold", dut.r_cnt[0], 40);
    chk("pause_not_running", running, 0);
    enable = 4'b0001;
    wait_pend(0, 200, cyc);
    chk("pause_delay", cyc, 102 + 50 - 41 - 49);
    cleanup();

    // ---- ch1 one-shot, prescale=0, value=9: 1 edge into RUN + 10 ticks
    set_value(1, 32'd9);
    mode      = 4'b0010;
    global_en = 1'b1;
    enable    = 4'b0010;
    wait_pend(1, 50, cyc);
    chk("ch1_oneshot_expiry", cyc, 11);
    chk("ch1_done_not_running", running[1], 0);
    irq_ack[1] = 1'b1;
    tick();
    irq_ack[1] = 1'b0;
    run(30);
    chk("ch1_no_reexpiry", pending[1], 0);
    chk("ch1_still_done", running[1], 0);
    chk("ch1_done_cnt", dut.r_cnt[1], 0);
    clear[1] = 1'b1;
    tick();
    clear[1] = 1'b0;
    chk("ch1_clear_idle", running[1], 0);
    tick();
    chk("ch1_clear_run", running[1], 1);
    wait_pend(1, 50, cyc);
    chk("ch1_reexpiry", cyc, 10);
    cleanup();

    // ---- same-cycle events on ch2, prescale=0, value=4: period 5
    set_value(2, 32'd4);
    global_en = 1'b1;
    enable    = 4'b0100;
    wait_pend(2, 50, cyc);
    chk("ch2_first_expiry", cyc, 6);
    irq_ack[2] = 1'b1;
    tick();
    irq_ack[2] = 1'b0;
    run(3);
    chk("ch2_acked", pending[2], 0);
    irq_ack[2] = 1'b1;           // lands on the next expiry edge
    tick();
    irq_ack[2] = 1'b0;
    chk("expiry_beats_ack", pending[2], 1);
    run(4);
    clear[2] = 1'b1;             // lands on the next expiry edge
    tick();
    clear[2] = 1'b0;
    chk("clear_beats_expiry_pend", pending[2], 0);
    chk("clear_beats_expiry_cnt", dut.r_cnt[2], 0);
    chk("clear_beats_expiry_idle", running[2], 0);
    cleanup();

    // ---- masked ch3, value=2: expiry after 4 edges, no irq until unmasked
    set_value(3, 32'd2);
    irq_mask  = 4'b0111;
    global_en = 1'b1;
    enable    = 4'b1000;
    wait_pend(3, 50, cyc);
    chk("ch3_expiry", cyc, 4);
    chk("ch3_pending_vec", pending, 4'b1000);
    chk("ch3_masked_irq", irq, 0);
    irq_mask = 4'b1111;
    tick();
    chk("ch3_unmasked_irq", irq, 1);

    // ---- asynchronous reset mid-count
    run(1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pending", pending, 0);
    chk("async_rst_running", running, 0);
    chk("async_rst_irq", irq, 0);
    chk("async_rst_cnt", dut.r_cnt[3], 0);
    tick();
    rst_n = 1'b1;
    cleanup();

`ifdef MULTI_TIMER_PWM_EN
    // ---- PWM on ch2: value=9, duty=3 -> 3 high clocks in every 10
    begin
      int highs;
      set_value(2, 32'd9);
      duty[2*N_REG +: N_REG] = 32'd3;
      global_en = 1'b1;
      enable    = 4'b0100;
      run(5);
      highs = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (pwm[2]) highs++;
      end
      chk("pwm_duty3", highs, 6);
      duty[2*N_REG +: N_REG] = 32'd20;
      run(2);
      highs = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (pwm[2]) highs++;
      end
      chk("pwm_duty_full", highs, 20);
      cleanup();
      chk("pwm_idle_low", pwm, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
